// File: rtl/mul_pkg.sv
// mul_pkg: shared sequencer state, digit encodings and row-entry type for mul_row_sched.
// Row-entry fields are sized for the largest supported array (MUL_P digits, MUL_Q rows).
package mul_pkg;

    localparam int MUL_P  = 33;
    localparam int MUL_Q  = 33;
    localparam int ROW_DW = 2 * MUL_P;
    localparam int ROW_IW = (MUL_Q > 1) ? $clog2(MUL_Q) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam logic [1:0] D0 = 2'b00;
    localparam logic [1:0] D1 = 2'b01;
    localparam logic [1:0] D2 = 2'b10;

    typedef struct packed {
        logic [ROW_DW-1:0] data;
        logic [ROW_IW-1:0] idx;
        logic              last;
    } row_entry_t;

endpackage

// File: rtl/mul_row_fifo.sv
// mul_row_fifo: 2-entry FIFO of partial-product row entries with occupancy count.
// pop_i must only be asserted while valid_o is high.
module mul_row_fifo
    import mul_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  row_entry_t din_i,
    input  logic       pop_i,
    output row_entry_t dout_o,
    output logic       valid_o,
    output logic [1:0] count_o
);

    row_entry_t mem_q [2];
    row_entry_t mem_d [2];
    logic       wp_q, wp_d, rp_q, rp_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        if (push_i) mem_d[wp_q] = din_i;
        wp_d    = wp_q ^ push_i;
        rp_d    = rp_q ^ pop_i;
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rp_q];
    assign valid_o = count_q != 2'd0;
    assign count_o = count_q;

endmodule

// File: rtl/mul_row_sched.sv
// mul_row_sched: issues B digits LSB-first to the transform array and streams the returned rows.
// Define MUL_ROW_SCHED_PERF_EN to add the perf_busy_o / perf_stall_o saturating counters.
module mul_row_sched
    import mul_pkg::*;
#(
    parameter int P  = MUL_P,
    parameter int Q  = MUL_Q,
    parameter int IW = (Q > 1) ? $clog2(Q) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [2*P-1:0] a_i,
    input  logic [2*Q-1:0] b_i,
    output logic [2*P-1:0] mt_a_o,
    output logic [1:0]     mt_b_o,
    input  logic [2*P-1:0] mt_m_i,
    output logic           row_valid_o,
    input  logic           row_ready_i,
    output logic [2*P-1:0] row_data_o,
    output logic [IW-1:0]  row_idx_o,
    output logic           row_last_o,
`ifdef MUL_ROW_SCHED_PERF_EN
    output logic [15:0]    perf_busy_o,
    output logic [15:0]    perf_stall_o,
`endif
    output logic           busy_o
);

    state_e         state_q, state_d;
    logic           rdy_q;
    logic [2*P-1:0] a_q, a_d;
    logic [2*Q-1:0] b_q, b_d;
    logic [IW-1:0]  j_q, j_d, pidx_q, pidx_d;
    logic           plast_q, plast_d, inflight_q;
    logic           issue, pop, accept, lst, fifo_valid;
    logic [1:0]     count;
    row_entry_t     push_e, head;

    always_comb begin
        pop     = fifo_valid & row_ready_i;
        accept  = in_valid_i & in_ready_o;
        lst     = j_q == IW'(Q - 1);
        // Room is counted after this cycle's pop, so issue resumes on the first pop.
        issue   = (state_q == RUN) && ((3'(count) + 3'(inflight_q) - 3'(pop)) < 3'd2);
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        j_d     = j_q;
        pidx_d  = pidx_q;
        plast_d = plast_q;
        case (state_q)
            IDLE: if (accept) begin
                a_d     = a_i;
                b_d     = b_i;
                j_d     = '0;
                state_d = RUN;
            end
            RUN: if (issue) begin
                b_d     = b_q >> 2;
                j_d     = j_q + 1'b1;
                pidx_d  = j_q;
                plast_d = lst;
                if (lst) state_d = DRAIN;
            end
            DRAIN: if (!inflight_q && count == {1'b0, pop}) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            j_q        <= '0;
            pidx_q     <= '0;
            plast_q    <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= 1'b1;
            a_q        <= a_d;
            b_q        <= b_d;
            j_q        <= j_d;
            pidx_q     <= pidx_d;
            plast_q    <= plast_d;
            inflight_q <= issue;
        end
    end

    assign push_e = '{data: ROW_DW'(mt_m_i), idx: ROW_IW'(pidx_q), last: plast_q};

    mul_row_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .din_i   (push_e),
        .pop_i   (pop),
        .dout_o  (head),
        .valid_o (fifo_valid),
        .count_o (count)
    );

    assign in_ready_o  = rdy_q && state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign mt_a_o      = a_q;
    assign mt_b_o      = issue ? b_q[1:0] : D0;
    assign row_valid_o = fifo_valid;
    assign row_data_o  = head.data[2*P-1:0];
    assign row_idx_o   = head.idx[IW-1:0];
    assign row_last_o  = head.last;

`ifdef MUL_ROW_SCHED_PERF_EN
    logic [15:0] pb_q, pb_d, ps_q, ps_d;

    always_comb begin
        pb_d = accept ? 16'd0 : pb_q + 16'(busy_o && pb_q != 16'hFFFF);
        ps_d = accept ? 16'd0 : ps_q + 16'(state_q == RUN && !issue && ps_q != 16'hFFFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_q <= 16'd0;
            ps_q <= 16'd0;
        end else begin
            pb_q <= pb_d;
            ps_q <= ps_d;
        end
    end

    assign perf_busy_o  = pb_q;
    assign perf_stall_o = ps_q;
`endif

endmodule

// File: doc/mul_row_sched.md
# mul_row_sched

Sequencer that feeds the per-digit four-valued transform array (P digit cells, one shared 2-bit B digit, 1-cycle registered latency) and collects its outputs as partial-product rows. It accepts one operand pair (A: P digits, B: Q digits), issues the B digits LSB-first, one per cycle, against the latched A, and streams each returned P-digit row out with its index. It sits between the operand source and the row-reduction/accumulate stage of the multiplier.

## Interface
- P, 33: A operand width in 2-bit digits; matches the array width.
- Q, 33: B operand width in 2-bit digits, i.e. rows per operation, Q ≥ 1.
- IW, $clog2(Q) (min 1): row index width.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  sequencer accepts an operand pair.
- a_i  in  2P  A operand, digit k at [2k+1:2k].
- b_i  in  2Q  B operand, digit j at [2j+1:2j].
- mt_a_o  out  2P  A digits to the array.
- mt_b_o  out  2  B digit to the array.
- mt_m_i  in  2P  array result; reflects inputs from the previous cycle.
- row_valid_o  out  1  row available.
- row_ready_i  in  1  consumer accepts row.
- row_data_o  out  2P  partial-product row.
- row_idx_o  out  IW  B digit index j of the row.
- row_last_o  out  1  row is j = Q-1.
- busy_o  out  1  operation in progress, state ≠ IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: in_ready_o = 1. On in_valid_i & in_ready_o, latch A and B, set j = 0, and go to RUN.
- RUN issue condition: fifo_count + inflight − pop < 2.
  - pop = row_valid_o & row_ready_i.
  - inflight is a 1-bit flag set in any cycle a digit is issued.
- On issue: mt_b_o = B digit j, and inflight is set for the next cycle.
  - If j = Q-1, go to DRAIN; otherwise j increments.
- With no issue, mt_b_o = 2'b00. mt_a_o always drives the latched A (zero after reset).
- When inflight is set, mt_m_i is pushed into the 2-entry row FIFO with its j and last flag. mt_m_i is ignored otherwise.
- DRAIN: no issues. Return to IDLE when inflight = 0 and the FIFO is empty after this cycle's pop. in_ready_o rises the following cycle.
- Row order is strictly j = 0..Q-1. No row is dropped or duplicated under any backpressure pattern.
- Simultaneous push and pop on a full FIFO cannot occur; the issue rule guarantees this.
- Reset mid-operation: all in-flight and buffered rows are discarded, and the state goes to IDLE.
- Reset values: in_ready_o = 0 while rst_n is low, then 1. row_valid_o, busy_o, row_idx_o, row_last_o, row_data_o, mt_a_o and mt_b_o are all 0.

## Timing
- Acceptance edge E0:
  - digit 0 is issued in cycle E0+1;
  - mt_m_i for row 0 is valid in E0+2 and pushed;
  - row_valid_o for row 0 rises in E0+3.
- With row_ready_i held high, rows emerge back-to-back, one per cycle. Last row in E0+Q+2; busy_o falls and in_ready_o rises in E0+Q+3.
- With row_ready_i low, at most 2 rows are buffered, then issue stalls. Issue resumes in the same cycle as the first pop.
- row_data_o, row_idx_o and row_last_o are stable while row_valid_o is high and row_ready_i is low.

## Configuration
- MUL_ROW_SCHED_PERF_EN defined adds two outputs, each a 16-bit saturating counter cleared by reset and on each operand acceptance:
  - perf_busy_o counts cycles with busy_o = 1;
  - perf_stall_o counts RUN cycles with no issue.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package mul_pkg holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the digit encodings (D0 = 2'b00, D1 = 2'b01, D2 = 2'b10);
  - a row-entry struct {data, idx, last}.
- One sub-module: mul_row_fifo, a 2-entry FIFO of row entries with count output, push, and pop/valid.

## Test plan
- P=2, Q=2, a_i=4'b1000, b_i=4'b0010, row_ready_i=1 → row0 data 4'b1000 idx 0, row1 data 4'b0010 idx 1 with last=1, on cycles E0+3 and E0+4.
- Q=33, row_ready_i=1, random operands → 33 consecutive rows with no bubble; in_ready_o returns at E0+36.
- row_ready_i=0 for 10 cycles → exactly 2 rows buffered and issue stalled. Releasing ready yields rows in order with data matching the golden transform.
- Random row_ready_i toggling at 50% over 100 operations → scoreboard order and data exact, and no in_valid_i accepted while busy_o=1.
- rst_n asserted while in DRAIN with 2 rows buffered → all outputs 0 immediately. After release, a new operation produces only its own rows.
- With MUL_ROW_SCHED_PERF_EN, Q=4 and ready held low for 5 cycles → perf_stall_o equals the counted no-issue RUN cycles, and perf_busy_o equals the busy_o-high cycle count.
